// File: rtl/serial_add_sub_if.sv
// ---------------------------------------------------------------------------
// serial_add_sub_if
//   Groups the operand-side and result-side valid/ready channels of the
//   bit-serial adder/subtractor.
//
//   Operand channel : in_valid, in_ready, a, b, sub
//   Result channel  : out_valid, out_ready, result, cb_out, ovf, zero
//
//   Modports:
//     slave  - the serial_add_sub block (consumes operands, produces results)
//     master - the producer/consumer around it (drives operands, takes results)
// ---------------------------------------------------------------------------
interface serial_add_sub_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cb_out;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cb_out, ovf, zero
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cb_out, ovf, zero
  );

endinterface

// File: rtl/serial_add_sub.sv
// ---------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial two's-complement adder/subtractor. A single full-adder /
//   full-subtractor slice plus a carry/borrow flop processes one bit per
//   clock, LSB first, over WIDTH cycles. Cheap alternative to a ripple
//   adder when latency does not matter (mantissa add, exponent difference).
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - serial_add_sub_if.slave
//              in_valid/in_ready/a/b/sub     : operand handshake (IDLE only)
//              out_valid/out_ready           : result handshake (DONE only)
//              result                        : a+b or a-b, modulo 2^WIDTH
//              cb_out                        : carry out (add) / borrow out (sub)
//              ovf                           : signed overflow
//              zero                          : result == 0
//
//   Timing: operands accepted at edge T, out_valid high after edge T+WIDTH.
//   The visible result/flags only update when an operation completes, so
//   they stay stable in DONE and keep their value through IDLE and RUN.
// ---------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_sub_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;

  // Working registers for the operation in flight.
  logic [WIDTH-1:0] a_q,   a_d;
  logic [WIDTH-1:0] b_q,   b_d;
  logic             sub_q, sub_d;
  logic             cb_q,  cb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Architecturally visible result and flags.
  logic [WIDTH-1:0] result_q, result_d;
  logic             cb_out_q, cb_out_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;

  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             last_bit;

  // One-bit slice signals. Operands shift right, so bit 0 is always the
  // current bit; on the final bit a_q[0]/b_q[0] are the operand MSBs.
  logic             bit_r;
  logic             carry_nxt;
  logic [WIDTH-1:0] acc_shift;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would create order-dependent
  // races between flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  assign accept   = bus.in_valid & in_ready;
  assign last_bit = (cnt_q == LAST_BIT);

  always_comb begin
    // NOTE: a default assignment first in every always_comb keeps each
    // output driven on all paths, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)        state_d = RUN;
      RUN:     if (last_bit)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode (handshake flags are pure functions of state)
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: one full-adder / full-subtractor slice
  // -------------------------------------------------------------------------
  assign bit_r     = a_q[0] ^ b_q[0] ^ cb_q;
  assign carry_nxt = sub_q ? ((~a_q[0] & b_q[0]) | (cb_q & ~(a_q[0] ^ b_q[0])))
                           : (( a_q[0] & b_q[0]) | (cb_q &  (a_q[0] ^ b_q[0])));
  // New bits enter at the MSB side; after WIDTH shifts bit 0 lands at [0].
  assign acc_shift = {bit_r, acc_q[WIDTH-1:1]};

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    cb_d     = cb_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    cb_out_d = cb_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = bus.a;
          b_d   = bus.b;
          sub_d = bus.sub;
          cb_d  = 1'b0;
          cnt_d = '0;
        end
      end

      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cb_d  = carry_nxt;
        acc_d = acc_shift;
        if (last_bit) begin
          // Counter parks at the terminal count; it is cleared on next accept.
          result_d = acc_shift;
          cb_out_d = carry_nxt;
          // Signed overflow: operands effectively of equal sign (b inverted
          // for subtract) yet the result sign differs from a's sign.
          ovf_d    = sub_q ? ((a_q[0] != b_q[0]) & (bit_r != a_q[0]))
                           : ((a_q[0] == b_q[0]) & (bit_r != a_q[0]));
          zero_d   = ~|acc_shift;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      cb_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cb_out_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      cb_q     <= cb_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cb_out_q <= cb_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.cb_out    = cb_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sub
//   Self-checking bench for serial_add_sub (WIDTH = 32). Expected values come
//   from an arithmetic reference model (wide integer add/subtract and signed
//   range checks). Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_serial_add_sub;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cb;
    logic             ovf;
    logic             zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic             s);
    exp_t   e;
    longint ua, ub, sa, sb, ufull, sfull;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (!s) begin
      ufull = ua + ub;
      sfull = sa + sb;
      e.cb  = (ufull >= 64'sd4294967296);
    end else begin
      ufull = ua - ub;
      sfull = sa - sb;
      e.cb  = (ua < ub);
    end
    e.result = ufull[WIDTH-1:0];
    e.ovf    = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
    e.zero   = (e.result == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands and wait for the accept edge; returns 1 time unit after it.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
  endtask

  // Count edges from the accept edge until out_valid, with a bound. Meanwhile
  // drive random garbage on operands, in_valid and out_ready; all of it must
  // be ignored outside IDLE/DONE respectively.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.sub       = 1'($urandom_range(0, 1));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input exp_t e);
    chk({tag, "_result"}, 64'(bus.result), 64'(e.result));
    chk({tag, "_cb"},     64'(bus.cb_out), 64'(e.cb));
    chk({tag, "_ovf"},    64'(bus.ovf),    64'(e.ovf));
    chk({tag, "_zero"},   64'(bus.zero),   64'(e.zero));
    chk({tag, "_in_ready_done"}, 64'(bus.in_ready), 64'd0);
  endtask

  task automatic finish_op(input string tag, input exp_t e);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_in_ready_idle"},  64'(bus.in_ready),  64'd1);
    chk({tag, "_result_hold"},    64'(bus.result),    64'(e.result));
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic s);
    exp_t e;
    int   lat;
    e = model(a, b, s);
    start_op(a, b, s);
    wait_done(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(WIDTH));
    check_result(tag, e);
    finish_op(tag, e);
  endtask

  initial begin
    exp_t             e;
    exp_t             e2;
    int               lat;
    logic [WIDTH-1:0] na, nb;
    logic             ns;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    rst_n         = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'(bus.result),    64'd0);
    chk("rst_cb",        64'(bus.cb_out),    64'd0);
    chk("rst_ovf",       64'(bus.ovf),       64'd0);
    chk("rst_zero",      64'(bus.zero),      64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    run_op("add_1_1",        32'h0000_0001, 32'h0000_0001, 1'b0);
    run_op("add_wrap",       32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("add_ovf",        32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sub_borrow",     32'h0000_0000, 32'h0000_0001, 1'b1);
    run_op("sub_ovf",        32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op("sub_equal",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    run_op("add_neg_ovf",    32'h8000_0000, 32'h8000_0000, 1'b0);

    // Backpressure: hold DONE for 5 cycles while in_valid pulses new operands
    e = model(32'hA5A5_0F0F, 32'h1234_5678, 1'b0);
    start_op(32'hA5A5_0F0F, 32'h1234_5678, 1'b0);
    wait_done(lat);
    chk("bp_latency", 64'(lat), 64'(WIDTH));
    check_result("bp", e);
    na = 32'h0;
    nb = 32'h0;
    ns = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      na           = $urandom;
      nb           = $urandom;
      ns           = 1'($urandom_range(0, 1));
      bus.a        = na;
      bus.b        = nb;
      bus.sub      = ns;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready_low",   64'(bus.in_ready),  64'd0);
      chk("bp_result_stable",  64'(bus.result),    64'(e.result));
      chk("bp_cb_stable",      64'(bus.cb_out),    64'(e.cb));
    end
    // Output handshake with in_valid still high: no accept on this edge.
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    // in_valid still high: accept resumes on the next edge with the last operands.
    e2 = model(na, nb, ns);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_resume_accept", 64'(bus.in_ready), 64'd0);
    wait_done(lat);
    chk("bp_resume_latency", 64'(lat), 64'(WIDTH));
    check_result("bp_resume", e2);
    finish_op("bp_resume", e2);

    // Reset in the middle of RUN (at bit 10)
    start_op(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("midrst_result",    64'(bus.result),    64'd0);
    chk("midrst_cb",        64'(bus.cb_out),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) lat++;
    end
    chk("midrst_no_pulse", 64'(lat), 64'd0);
    run_op("post_rst", 32'h1234_5678, 32'h0234_5678, 1'b1);
    chk("post_rst_result_exact", 64'(bus.result), 64'h1000_0000);

    // Randomized operations against the reference model
    for (int i = 0; i < 20; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rs;
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 5 == 0) rb = ra;  // exercise zero / equal operands
      run_op($sformatf("rand%0d", i), ra, rb, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
